dec_syndrome_stage: RTL

DEC_SYNDROME_STAGE -- requirements
Module: dec_syndrome_stage

---
 rtl/ecc_pkg.sv | 40 ++++
 rtl/dec_syndrome_calc.sv | 27 ++
 rtl/dec_syndrome_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: parity sizing, H-matrix columns, status codes
// and the statistics counter width.
package ecc_pkg;

  localparam int CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_CORRECTED = 2'd1,
    ERR_CHECKBIT  = 2'd2,
    ERR_UNCORR    = 2'd3
  } err_status_t;

  // Hamming check bits plus one overall-parity bit; an illegal width returns 1
  // so elaboration can reach the width assertion in the top.
  function automatic int parity_width(input int data_width);
    case (data_width)
      8:       return 5;
      16:      return 6;
      32:      return 7;
      default: return 1;
    endcase
  endfunction

  // Column of data bit idx: the (idx+1)-th integer >= 3 that is not a power of two.
  function automatic logic [6:0] h_col(input int idx);
    logic [6:0] col;
    int         seen;
    col  = '0;
    seen = 0;
    for (int v = 3; v < 128; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (seen == idx) col = 7'(v);
        seen++;
      end
    end
    return col;
  endfunction

endpackage

// File: rtl/dec_syndrome_calc.sv
// Combinational syndrome and overall-parity XOR tree for one received word.
module dec_syndrome_calc
  import ecc_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int PW         = parity_width(DATA_WIDTH),
  localparam int SW         = PW - 1
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [PW-1:0]         parity,
  output logic [SW-1:0]         syndrome,
  output logic                  overall
);

  // Check bit j contributes column 2^j, so the check bits seed the syndrome directly.
  always_comb begin
    logic [6:0] col;
    col      = '0;
    syndrome = parity[SW-1:0];
    for (int i = 0; i < DATA_WIDTH; i++) begin
      col = h_col(i);
      if (data[i]) syndrome = syndrome ^ col[SW-1:0];
    end
    overall = (^data) ^ (^parity);
  end

endmodule

// File: rtl/dec_syndrome_stage.sv
// Two-stage SECDED decode front end: stage 1 registers syndrome/parity/data,
// stage 2 classifies and presents the correction request; keeps error counters.
module dec_syndrome_stage
  import ecc_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  localparam int PARITY_WIDTH = parity_width(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [PARITY_WIDTH-1:0] in_parity,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_codeword,
  output logic [4:0]              whichColIsError,
  output logic                    flip_en,
  output logic [1:0]              err_status,
  input  logic                    clr_cnt,
  output logic [CNT_WIDTH-1:0]    corr_cnt,
  output logic [CNT_WIDTH-1:0]    uncorr_cnt
);

  localparam int SW = PARITY_WIDTH - 1;

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
    $error("dec_syndrome_stage: DATA_WIDTH must be 8, 16 or 32");
  end

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [SW-1:0]         s1_syn;
  logic                  s1_par;
  logic [SW-1:0]         calc_syn;
  logic                  calc_par;
  logic                  s1_advance;
  logic                  s2_advance;
  logic                  out_fire;
  logic                  col_hit;
  logic [4:0]            col_idx;
  logic                  syn_pow2;
  err_status_t           cls;
  logic                  cls_flip;

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = s1_advance;
  assign out_fire   = out_valid && out_ready;

  dec_syndrome_calc #(.DATA_WIDTH(DATA_WIDTH)) u_calc (
    .data     (in_data),
    .parity   (in_parity),
    .syndrome (calc_syn),
    .overall  (calc_par)
  );

  // Stage 1: capture the word with its syndrome and overall parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_syn  <= calc_syn;
        s1_par  <= calc_par;
      end
    end
  end

  // Classify the stage-1 syndrome; data columns are never powers of two.
  always_comb begin
    logic [6:0] col;
    col      = '0;
    col_hit  = 1'b0;
    col_idx  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      col = h_col(i);
      if (!col_hit && s1_syn == col[SW-1:0]) begin
        col_hit = 1'b1;
        col_idx = 5'(i);
      end
    end
    syn_pow2 = (s1_syn != '0) && ((s1_syn & (s1_syn - SW'(1))) == '0);
    cls      = ERR_UNCORR;
    cls_flip = 1'b0;
    if (s1_syn == '0) begin
      cls = s1_par ? ERR_CHECKBIT : ERR_NONE;
    end else if (s1_par && col_hit) begin
      cls      = ERR_CORRECTED;
      cls_flip = 1'b1;
    end else if (s1_par && syn_pow2) begin
      cls = ERR_CHECKBIT;
    end
  end

  // Stage 2: register the classification; everything holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_codeword    <= '0;
      whichColIsError <= '0;
      flip_en         <= 1'b0;
      err_status      <= ERR_NONE;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_codeword    <= s1_data;
        whichColIsError <= cls_flip ? col_idx : 5'd0;
        flip_en         <= cls_flip;
        err_status      <= cls;
      end
    end
  end

  // Saturating statistics; a clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      if ((err_status == ERR_CORRECTED || err_status == ERR_CHECKBIT) && corr_cnt != '1)
        corr_cnt <= corr_cnt + CNT_WIDTH'(1);
      if (err_status == ERR_UNCORR && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
